key_debounce_sync: RTL and testbench

//  Multi-channel key conditioner for the piano front end: per channel, synchronises a raw

---
 rtl/piano_key_pkg.sv | 16 +
 rtl/key_debounce_chan.sv | 115 +++++++++++
 rtl/key_debounce_sync.sv | 34 +++
 tb/tb_key_debounce_sync.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/piano_key_pkg.sv
// Shared key-conditioning constants and types for the piano front end.
// Defaults assume the 50 MHz board clock (50000 cycles = 1 ms stability window).
package piano_key_pkg;

  localparam logic KEY_PRESSED  = 1'b1;
  localparam logic KEY_RELEASED = 1'b0;

  localparam int DEFAULT_SYNC_STAGES  = 2;
  localparam int DEFAULT_DEBOUNCE_CNT = 50000;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } chan_state_e;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: synchroniser chain, stability counter, registered level and edge pulses.
// Press/release pulses exist only when KEY_DEBOUNCE_EDGE_EN is defined; otherwise tied to 0.
import piano_key_pkg::*;

module key_debounce_chan #(
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   key_sync_s;
  chan_state_e            state_r;
  chan_state_e            state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_r;
  logic                   level_nxt_s;

  assign key_sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain for the asynchronous key pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key_raw};
    end
  end

  // Filter state, stability counter and accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_STABLE;
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
    end
  end

  // Next-state: any return to the accepted level restarts the stability window.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    case (state_r)
      ST_STABLE: begin
        if (key_sync_s != level_r) begin
          if (cnt_r == CNT_LAST) begin
            level_nxt_s = key_sync_s;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s   = cnt_r + 1'b1;
            state_nxt_s = ST_CHANGING;
          end
        end else begin
          cnt_nxt_s = '0;
        end
      end
      ST_CHANGING: begin
        if (key_sync_s == level_r) begin
          cnt_nxt_s   = '0;
          state_nxt_s = ST_STABLE;
        end else if (cnt_r == CNT_LAST) begin
          level_nxt_s = key_sync_s;
          cnt_nxt_s   = '0;
          state_nxt_s = ST_STABLE;
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_STABLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign key_level = level_r;

`ifdef KEY_DEBOUNCE_EDGE_EN
  logic press_r;
  logic release_r;

  // Pulses are registered on the same edge that updates the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= (level_nxt_s != level_r) && (level_nxt_s == KEY_PRESSED);
      release_r <= (level_nxt_s != level_r) && (level_nxt_s == KEY_RELEASED);
    end
  end

  assign key_press   = press_r;
  assign key_release = release_r;
`else
  assign key_press   = 1'b0;
  assign key_release = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_sync.sv
// Multi-channel key conditioner: WIDTH independent synchronise + debounce channels.
// Edge pulses are enabled by defining KEY_DEBOUNCE_EDGE_EN.
import piano_key_pkg::*;

module key_debounce_sync #(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT
) (
  input  logic             DCLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] KEY_IN,
  output logic [WIDTH-1:0] KEY_OUT,
  output logic [WIDTH-1:0] KEY_PRESS,
  output logic [WIDTH-1:0] KEY_RELEASE
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    key_debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_chan (
      .clk        (DCLK),
      .rst_n      (RSTN),
      .key_raw    (KEY_IN[i]),
      .key_level  (KEY_OUT[i]),
      .key_press  (KEY_PRESS[i]),
      .key_release(KEY_RELEASE[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync (WIDTH=4, SYNC_STAGES=2, CNT_W=4, DEBOUNCE_CNT=4).
// Pulse expectations follow KEY_DEBOUNCE_EDGE_EN; with it undefined pulses must stay 0.
module tb_key_debounce_sync;

`ifdef KEY_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       DCLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [3:0] KEY_IN = 4'h0;
  logic [3:0] KEY_OUT;
  logic [3:0] KEY_PRESS;
  logic [3:0] KEY_RELEASE;

  int tests = 0;
  int fails = 0;

  key_debounce_sync #(
    .WIDTH(4), .SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE_CNT(4)
  ) dut (
    .DCLK(DCLK), .RSTN(RSTN), .KEY_IN(KEY_IN),
    .KEY_OUT(KEY_OUT), .KEY_PRESS(KEY_PRESS), .KEY_RELEASE(KEY_RELEASE)
  );

  always #5 DCLK = ~DCLK;

  task automatic step();
    @(posedge DCLK);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] k);
    RSTN   = 1'b0;
    KEY_IN = k;
    step();
    step();
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] exp_v;
    RSTN   = 1'b0;
    KEY_IN = 4'hF;
    step();
    step();
    tests++;
    if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== 12'h000) begin
      fails++;
      $display("FAIL reset_hold: out/press/rel=%h expected 000", {KEY_OUT, KEY_PRESS, KEY_RELEASE});
    end
    RSTN = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_v = {(e >= 6) ? 4'hF : 4'h0, (EDGE_EN && e == 6) ? 4'hF : 4'h0, 4'h0};
      tests++;
      if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== exp_v) begin
        fails++;
        $display("FAIL reset_release edge %0d: out/press/rel=%h expected %h", e, {KEY_OUT, KEY_PRESS, KEY_RELEASE}, exp_v);
      end
    end
    #2;
    RSTN = 1'b0;
    #1;
    tests++;
    if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== 12'h000) begin
      fails++;
      $display("FAIL reset_async: out/press/rel=%h expected 000", {KEY_OUT, KEY_PRESS, KEY_RELEASE});
    end
  endtask

  task automatic test_clean_press();
    logic [11:0] exp_v;
    do_reset(4'h0);
    KEY_IN = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_v = {(e >= 6) ? 4'b0001 : 4'b0000, (EDGE_EN && e == 6) ? 4'b0001 : 4'b0000, 4'b0000};
      tests++;
      if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== exp_v) begin
        fails++;
        $display("FAIL clean_press edge %0d: out/press/rel=%h expected %h", e, {KEY_OUT, KEY_PRESS, KEY_RELEASE}, exp_v);
      end
    end
    KEY_IN = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_v = {(e < 6) ? 4'b0001 : 4'b0000, 4'b0000, (EDGE_EN && e == 6) ? 4'b0001 : 4'b0000};
      tests++;
      if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== exp_v) begin
        fails++;
        $display("FAIL clean_release edge %0d: out/press/rel=%h expected %h", e, {KEY_OUT, KEY_PRESS, KEY_RELEASE}, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    logic [11:0] exp_v;
    int          pulses;
    pulses = 0;
    do_reset(4'h0);
    for (int c = 0; c < 16; c++) begin
      KEY_IN[1] = (c >= 8) ? 1'b1 : (((c / 2) % 2) == 0);
      step();
      if (KEY_PRESS[1] === 1'b1) pulses++;
      exp_v = {(c + 1 >= 14) ? 4'b0010 : 4'b0000, (EDGE_EN && c + 1 == 14) ? 4'b0010 : 4'b0000, 4'b0000};
      tests++;
      if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== exp_v) begin
        fails++;
        $display("FAIL bounce edge %0d: out/press/rel=%h expected %h", c + 1, {KEY_OUT, KEY_PRESS, KEY_RELEASE}, exp_v);
      end
    end
    tests++;
    if (pulses != (EDGE_EN ? 1 : 0)) begin
      fails++;
      $display("FAIL bounce_pulse_count: got %0d expected %0d", pulses, EDGE_EN ? 1 : 0);
    end
  endtask

  task automatic test_glitch();
    do_reset(4'h0);
    for (int c = 0; c < 12; c++) begin
      KEY_IN[2] = (c < 3);
      step();
      tests++;
      if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== 12'h000) begin
        fails++;
        $display("FAIL glitch edge %0d: out/press/rel=%h expected 000", c + 1, {KEY_OUT, KEY_PRESS, KEY_RELEASE});
      end
    end
  endtask

  task automatic test_parallel();
    logic [11:0] exp_v;
    do_reset(4'h0);
    KEY_IN = 4'b1010;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_v = {(e >= 6) ? 4'b1010 : 4'b0000, (EDGE_EN && e == 6) ? 4'b1010 : 4'b0000, 4'b0000};
      tests++;
      if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== exp_v) begin
        fails++;
        $display("FAIL parallel edge %0d: out/press/rel=%h expected %h", e, {KEY_OUT, KEY_PRESS, KEY_RELEASE}, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [11:0] exp_v;
    do_reset(4'b1000);
    for (int e = 1; e <= 4; e++) step();
    RSTN = 1'b0;
    #1;
    tests++;
    if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== 12'h000) begin
      fails++;
      $display("FAIL midcount_reset: out/press/rel=%h expected 000", {KEY_OUT, KEY_PRESS, KEY_RELEASE});
    end
    step();
    step();
    RSTN = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_v = {(e >= 6) ? 4'b1000 : 4'b0000, (EDGE_EN && e == 6) ? 4'b1000 : 4'b0000, 4'b0000};
      tests++;
      if ({KEY_OUT, KEY_PRESS, KEY_RELEASE} !== exp_v) begin
        fails++;
        $display("FAIL midcount_restart edge %0d: out/press/rel=%h expected %h", e, {KEY_OUT, KEY_PRESS, KEY_RELEASE}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_parallel();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
